tri_scan_sched: RTL and testbench

TRI_SCAN_SCHED -- requirements
Module: tri_scan_sched

---
 rtl/tri_scan_sched_pkg.sv | 15 +
 rtl/tri_scan_sched_if.sv | 14 +
 rtl/tri_scan_sched_scan_counter.sv | 48 ++++
 rtl/tri_scan_sched.sv | 111 +++++++++++
 tb/tb_tri_scan_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tri_scan_sched_pkg.sv
// Shared definitions for the triangle scan scheduler: coordinate width and FSM state codes.
package tri_pkg;

   localparam int COORD_W = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD1 = 3'd1;
   localparam state_t ST_LOAD2 = 3'd2;
   localparam state_t ST_ISSUE = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;
   localparam state_t ST_FIN   = 3'd5;

endpackage

// File: rtl/tri_scan_sched_if.sv
// Test-point / result handshake between the scan scheduler and the point-in-triangle PE.
interface tri_scan_sched_if #(
   parameter int COORD_W = tri_pkg::COORD_W
);
   logic [COORD_W-1:0] tx;
   logic [COORD_W-1:0] ty;
   logic               t_valid;
   logic               t_ready;
   logic               r_valid;
   logic               r_inside;

   modport master (output tx, ty, t_valid, input t_ready, r_valid, r_inside);
   modport slave  (input tx, ty, t_valid, output t_ready, r_valid, r_inside);
endinterface

// File: rtl/tri_scan_sched_scan_counter.sv
// Bounding-box raster counter: loads the box, walks it row-major, flags the final point.
module scan_counter #(
   parameter int COORD_W = tri_pkg::COORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               adv,
   input  logic [COORD_W-1:0] xmin,
   input  logic [COORD_W-1:0] xmax,
   input  logic [COORD_W-1:0] ymin,
   input  logic [COORD_W-1:0] ymax,
   output logic [COORD_W-1:0] sx,
   output logic [COORD_W-1:0] sy,
   output logic               last
);

   logic [COORD_W-1:0] x_lo;
   logic [COORD_W-1:0] x_hi;
   logic [COORD_W-1:0] y_hi;

   assign last = (sx == x_hi) && (sy == y_hi);

   // Advancing is suppressed on the last point so a 0..7 box never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_lo <= '0;
         x_hi <= '0;
         y_hi <= '0;
         sx   <= '0;
         sy   <= '0;
      end else if (load) begin
         x_lo <= xmin;
         x_hi <= xmax;
         y_hi <= ymax;
         sx   <= xmin;
         sy   <= ymin;
      end else if (adv && !last) begin
         if (sx == x_hi) begin
            sx <= x_lo;
            sy <= sy + COORD_W'(1);
         end else begin
            sx <= sx + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/tri_scan_sched.sv
// Triangle scan scheduler: captures three vertices, issues every bounding-box point to the PE,
// emits a pixel strobe for each inside result and pulses done after the last one.
//
//   state | meaning
//   IDLE  | waiting for nt, V0 captured on nt
//   LOAD1 | capture V1
//   LOAD2 | capture V2, load bounding box into scan counter
//   ISSUE | present scan point to PE
//   WAIT  | point accepted, waiting for PE result
//   FIN   | one-cycle done pulse
module tri_scan_sched #(
   parameter int COORD_W = tri_pkg::COORD_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  nt,
   input  logic [COORD_W-1:0]    xi,
   input  logic [COORD_W-1:0]    yi,
   output logic                  busy,
   tri_scan_sched_if.master      pe,
   output logic                  po,
   output logic [COORD_W-1:0]    xo,
   output logic [COORD_W-1:0]    yo,
   output logic                  done
);
   import tri_pkg::*;

   function automatic logic [COORD_W-1:0] umin(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [COORD_W-1:0] umax(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic [COORD_W-1:0] v0x, v0y, v1x, v1y;
   logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
   logic [COORD_W-1:0] sx, sy;
   logic               last;
   logic               sc_load;
   logic               sc_adv;

   // V2 is still on xi/yi during LOAD2, so the box is formed straight from the inputs.
   assign xmin = umin(umin(v0x, v1x), xi);
   assign xmax = umax(umax(v0x, v1x), xi);
   assign ymin = umin(umin(v0y, v1y), yi);
   assign ymax = umax(umax(v0y, v1y), yi);

   assign sc_load = (state == ST_LOAD2);
   assign sc_adv  = (state == ST_WAIT) && pe.r_valid;

   scan_counter #(.COORD_W(COORD_W)) u_scan (
      .clk  (clk),
      .rst  (rst),
      .load (sc_load),
      .adv  (sc_adv),
      .xmin (xmin),
      .xmax (xmax),
      .ymin (ymin),
      .ymax (ymax),
      .sx   (sx),
      .sy   (sy),
      .last (last)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (nt) state_nxt = ST_LOAD1;
         ST_LOAD1: state_nxt = ST_LOAD2;
         ST_LOAD2: state_nxt = ST_ISSUE;
         ST_ISSUE: if (pe.t_ready) state_nxt = ST_WAIT;
         ST_WAIT:  if (pe.r_valid) state_nxt = last ? ST_FIN : ST_ISSUE;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         v0x   <= '0;
         v0y   <= '0;
         v1x   <= '0;
         v1y   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && nt) begin
            v0x <= xi;
            v0y <= yi;
         end
         if (state == ST_LOAD1) begin
            v1x <= xi;
            v1y <= yi;
         end
      end
   end

   assign pe.tx      = sx;
   assign pe.ty      = sy;
   assign pe.t_valid = (state == ST_ISSUE);

   assign po   = (state == ST_WAIT) && pe.r_valid && pe.r_inside;
   assign xo   = po ? sx : '0;
   assign yo   = po ? sy : '0;
   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FIN);

endmodule

// File: tb/tb_tri_scan_sched.sv
// Directed and randomized bench for tri_scan_sched with a behavioural raster/PE reference.
module tb_tri_scan_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       nt  = 1'b0;
   logic [2:0] xi  = '0;
   logic [2:0] yi  = '0;
   logic       busy, po, done;
   logic [2:0] xo, yo;

   int n_chk  = 0;
   int n_fail = 0;

   tri_scan_sched_if #(.COORD_W(3)) pe_if ();

   tri_scan_sched #(.COORD_W(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .nt   (nt),
      .xi   (xi),
      .yi   (yi),
      .busy (busy),
      .pe   (pe_if),
      .po   (po),
      .xo   (xo),
      .yo   (yo),
      .done (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inclusive edge-function test: inside when all three edge values share a sign or are zero.
   function automatic bit pt_in_tri(input int ax, ay, bx, by, cx, cy, px, py);
      int e0, e1, e2;
      e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
      e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
      e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   function automatic int min3(input int a, b, c);
      int m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic int max3(input int a, b, c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   task automatic run_tri(input int ax, ay, bx, by, cx, cy,
                          input int stall_x, stall_y, input int abort_at, input bit rand_mode);
      int  qx[$];
      int  qy[$];
      int  n, idx, cyc, stall, po_exp, po_cnt;
      bit  waiting, aborted, ins;

      for (int y = min3(ay, by, cy); y <= max3(ay, by, cy); y++)
         for (int x = min3(ax, bx, cx); x <= max3(ax, bx, cx); x++) begin
            qx.push_back(x);
            qy.push_back(y);
         end
      n = qx.size();
      idx = 0; cyc = 0; stall = 0; po_exp = 0; po_cnt = 0;
      waiting = 0; aborted = 0;

      @(negedge clk);
      nt = 1'b1; xi = 3'(ax); yi = 3'(ay);
      pe_if.t_ready = 1'b0; pe_if.r_valid = 1'b0; pe_if.r_inside = 1'b0;
      #1 chk("idle_busy", busy, 0);
      @(negedge clk);
      nt = 1'($urandom_range(1)); xi = 3'(bx); yi = 3'(by);
      #1 chk("load1_busy", busy, 1);
      @(negedge clk);
      nt = 1'($urandom_range(1)); xi = 3'(cx); yi = 3'(cy);
      pe_if.r_valid = 1'($urandom_range(1));
      #1 chk("load2_busy", busy, 1);
      chk("load2_tvalid", pe_if.t_valid, 0);

      while (idx < n && cyc < 3000 && !aborted) begin
         @(negedge clk);
         cyc++;
         nt = 1'($urandom_range(1));
         xi = 3'($urandom_range(7));
         yi = 3'($urandom_range(7));
         if (!waiting) begin
            if (idx == abort_at) begin
               rst = 1'b1;
               aborted = 1;
               @(negedge clk);
               rst = 1'b0; nt = 1'b0;
               pe_if.t_ready = 1'b0; pe_if.r_valid = 1'b0;
               #1 chk("abort_busy", busy, 0);
               chk("abort_tvalid", pe_if.t_valid, 0);
               chk("abort_done", done, 0);
               chk("abort_po", po, 0);
            end else begin
               pe_if.t_ready  = rand_mode ? ($urandom_range(2) != 0) : 1'b1;
               if (qx[idx] == stall_x && qy[idx] == stall_y && stall < 5) begin
                  pe_if.t_ready = 1'b0;
                  stall++;
               end
               pe_if.r_valid  = ($urandom_range(3) == 0);
               pe_if.r_inside = 1'($urandom_range(1));
               #1 chk("issue_tvalid", pe_if.t_valid, 1);
               chk("issue_tx", pe_if.tx, qx[idx]);
               chk("issue_ty", pe_if.ty, qy[idx]);
               chk("issue_po", po, 0);
               chk("issue_done", done, 0);
               if (pe_if.t_ready) waiting = 1;
            end
         end else begin
            ins = pt_in_tri(ax, ay, bx, by, cx, cy, qx[idx], qy[idx]);
            pe_if.t_ready  = 1'($urandom_range(1));
            pe_if.r_valid  = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            pe_if.r_inside = ins;
            #1 chk("wait_tvalid", pe_if.t_valid, 0);
            chk("wait_done", done, 0);
            chk("wait_po", po, pe_if.r_valid && ins);
            if (po) po_cnt++;
            if (pe_if.r_valid) begin
               if (ins) begin
                  chk("pix_x", xo, qx[idx]);
                  chk("pix_y", yo, qy[idx]);
                  po_exp++;
               end
               idx++;
               waiting = 0;
            end
         end
      end

      if (!aborted) begin
         chk("cycle_budget", idx, n);
         if (!rand_mode) chk("throughput", cyc, 2 * n + stall);
         @(negedge clk);
         nt = 1'b0; pe_if.t_ready = 1'b1; pe_if.r_valid = 1'b1; pe_if.r_inside = 1'b1;
         #1 chk("fin_done", done, 1);
         chk("fin_po", po, 0);
         chk("fin_tvalid", pe_if.t_valid, 0);
         @(negedge clk);
         pe_if.t_ready = 1'b0; pe_if.r_valid = 1'b0; pe_if.r_inside = 1'b0;
         #1 chk("post_done", done, 0);
         chk("post_busy", busy, 0);
         chk("post_tvalid", pe_if.t_valid, 0);
         chk("po_count", po_cnt, po_exp);
      end
   endtask

   initial begin
      int ax, ay, bx, by, cx, cy;
      pe_if.t_ready = 1'b0; pe_if.r_valid = 1'b0; pe_if.r_inside = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("rst_busy", busy, 0);
      chk("rst_tvalid", pe_if.t_valid, 0);
      chk("rst_po", po, 0);
      chk("rst_done", done, 0);
      chk("rst_tx", pe_if.tx, 0);
      chk("rst_ty", pe_if.ty, 0);
      chk("rst_xo", xo, 0);
      chk("rst_yo", yo, 0);
      rst = 1'b0;

      run_tri(1, 1, 5, 1, 1, 4, 2, 2, -1, 0);
      run_tri(3, 3, 3, 3, 3, 3, -1, -1, -1, 0);
      run_tri(0, 0, 7, 0, 0, 7, -1, -1, -1, 1);
      run_tri(0, 0, 7, 0, 0, 7, -1, -1, 9, 1);
      run_tri(0, 0, 1, 0, 0, 1, -1, -1, -1, 0);
      run_tri(7, 7, 0, 0, 7, 0, -1, -1, -1, 0);

      for (int t = 0; t < 6; t++) begin
         ax = $urandom_range(7); ay = $urandom_range(7);
         bx = $urandom_range(7); by = $urandom_range(7);
         cx = $urandom_range(7); cy = $urandom_range(7);
         run_tri(ax, ay, bx, by, cx, cy, -1, -1, -1, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
